// File: rtl/aldff_load_sched_if.sv
// Bus between the requester fabric and the shared async-load register scheduler.
// Signal names match the flip-flop instrumentation (_t = 32-bit taint companion).
interface aldff_load_sched_if #(
    parameter int WIDTH = 2,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       REQ;
    logic [31:0]           REQ_t;
    logic [NREQ*WIDTH-1:0] AD_IN;
    logic [31:0]           AD_IN_t;
    logic [NREQ-1:0]       GNT;
    logic [31:0]           GNT_t;
    logic                  ALOAD;
    logic [31:0]           ALOAD_t;
    logic [WIDTH-1:0]      AD;
    logic [31:0]           AD_t;
    logic                  BUSY;

    // Requester fabric side
    modport master (
        output REQ, REQ_t, AD_IN, AD_IN_t,
        input  GNT, GNT_t, ALOAD, ALOAD_t, AD, AD_t, BUSY
    );

    // Scheduler side
    modport slave (
        input  REQ, REQ_t, AD_IN, AD_IN_t,
        output GNT, GNT_t, ALOAD, ALOAD_t, AD, AD_t, BUSY
    );
endinterface

// File: rtl/aldff_load_sched.sv
// Round-robin scheduler owning the ALOAD/AD pins of one shared async-load
// register. Flow per grant: IDLE -> ARB -> LOAD (HOLD_CYCLES) -> RELEASE.
// ALOAD is registered from the LOAD state, so it trails LOAD by one cycle and
// is high for exactly HOLD_CYCLES cycles, overlapping the first RELEASE cycle.
// Optional feature macro: ALDFF_SCHED_TAINT_EN (taint companions computed;
// when undefined all _t outputs are tied to zero).
module aldff_load_sched #(
    parameter int WIDTH       = 2,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 1
) (
    input logic               CLK,
    input logic               ARST_N,
    aldff_load_sched_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [3:0]       cnt;
    logic [NREQ-1:0]  gnt;
    logic             aload;
    logic [WIDTH-1:0] ad;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    cand;
    logic [WIDTH-1:0] win_ad;
    logic             arb_ok;

    // Round-robin pick: scan from ptr upwards; walking the offsets downwards
    // lets the smallest offset overwrite the others.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (bus.REQ[cand] == 1'b1) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Mux out the candidate winner's load value.
    always_comb begin
        win_ad = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == PW'(i)) win_ad = bus.AD_IN[i*WIDTH +: WIDTH];
        end
    end

    // An X/Z request vector aborts arbitration ($isunknown folds to 0 in hardware).
    assign arb_ok = pick_vld && !$isunknown(bus.REQ);

    // Main FSM plus the registered GNT/ALOAD/AD outputs.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= S_IDLE;
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            aload <= 1'b0;
            ad    <= '0;
        end else begin
            aload <= (state == S_LOAD);
            case (state)
                S_IDLE: if (bus.REQ != '0) state <= S_ARB;
                S_ARB: begin
                    if (!arb_ok) begin
                        state <= S_IDLE;
                    end else begin
                        gnt   <= NREQ'(1) << pick_idx;
                        ad    <= win_ad;
                        win   <= pick_idx;
                        cnt   <= 4'(HOLD_CYCLES);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt <= 4'd1) state <= S_REL;
                    else             cnt   <= cnt - 4'd1;
                end
                default: begin
                    // Hold the grant until the winner acknowledges by dropping REQ.
                    if (bus.REQ[win] == 1'b0) begin
                        gnt   <= '0;
                        ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.GNT   = gnt;
    assign bus.ALOAD = aload;
    assign bus.AD    = ad;
    assign bus.BUSY  = (state != S_IDLE);

`ifdef ALDFF_SCHED_TAINT_EN
    logic [31:0] gnt_t;
    logic [31:0] aload_t;
    logic [31:0] ad_t;

    // Taints are captured at arbitration; an X in the winning value drops them
    // to zero, mirroring the flip-flop's X rule. AD_t lives as long as AD.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            gnt_t   <= '0;
            aload_t <= '0;
            ad_t    <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (!arb_ok || $isunknown(win_ad)) begin
                        gnt_t   <= '0;
                        aload_t <= '0;
                        ad_t    <= '0;
                    end else begin
                        gnt_t   <= bus.REQ_t;
                        aload_t <= bus.REQ_t;
                        ad_t    <= bus.AD_IN_t | bus.REQ_t;
                    end
                end
                S_REL: begin
                    if (bus.REQ[win] == 1'b0) begin
                        gnt_t   <= '0;
                        aload_t <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.GNT_t   = gnt_t;
    assign bus.ALOAD_t = aload_t;
    assign bus.AD_t    = ad_t;
`else
    logic unused_taint;
    assign unused_taint = ^{bus.REQ_t, bus.AD_IN_t};
    assign bus.GNT_t    = '0;
    assign bus.ALOAD_t  = '0;
    assign bus.AD_t     = '0;
`endif
endmodule

// File: tb/tb_aldff_load_sched.sv
// Bench for aldff_load_sched: directed scenarios plus randomized requesters,
// checked every cycle against a timeline model of the grant sequence.
module tb_aldff_load_sched;
    localparam int H = 1;
`ifdef ALDFF_SCHED_TAINT_EN
    localparam bit TAINT = 1'b1;
`else
    localparam bit TAINT = 1'b0;
`endif

    logic CLK = 1'b0;
    logic ARST_N = 1'b1;
    always #5 CLK = ~CLK;

    aldff_load_sched_if #(.WIDTH(2), .NREQ(4)) ifa ();
    aldff_load_sched_if #(.WIDTH(2), .NREQ(4)) ifb ();

    aldff_load_sched #(.WIDTH(2), .NREQ(4), .HOLD_CYCLES(H)) dut  (.CLK(CLK), .ARST_N(ARST_N), .bus(ifa));
    aldff_load_sched #(.WIDTH(2), .NREQ(4), .HOLD_CYCLES(3)) dut3 (.CLK(CLK), .ARST_N(ARST_N), .bus(ifb));

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: a grant is a timeline anchored at the arbitration edge t_arb.
    bit          m_act;
    int          t_arb, m_win, m_ptr;
    logic [3:0]  e_gnt;
    logic        e_aload;
    logic [1:0]  e_ad;
    logic [31:0] e_gt, e_at, e_adt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 1'b0; m_ptr = 0; m_win = 0; t_arb = 0;
        e_gnt = '0; e_aload = 1'b0; e_ad = '0;
        e_gt = '0; e_at = '0; e_adt = '0;
    endtask

    task automatic model_step();
        logic [3:0] r;
        logic [1:0] s;
        bit found;
        r = ifa.REQ;
        if (!ARST_N) begin
            model_reset();
        end else if (!m_act) begin
            if (r != 4'b0) begin m_act = 1'b1; t_arb = cyc + 1; end
        end else if (cyc == t_arb) begin
            if (r == 4'b0 || $isunknown(r)) begin
                m_act = 1'b0; e_gt = '0; e_at = '0; e_adt = '0;
            end else begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && r[(m_ptr + k) % 4] === 1'b1) begin
                        found = 1'b1; m_win = (m_ptr + k) % 4;
                    end
                end
                s = 2'(ifa.AD_IN >> (2 * m_win));
                e_gnt = 4'(1 << m_win);
                e_ad  = s;
                if ($isunknown(s)) begin
                    e_gt = '0; e_at = '0; e_adt = '0;
                end else begin
                    e_gt = ifa.REQ_t; e_at = ifa.REQ_t; e_adt = ifa.AD_IN_t | ifa.REQ_t;
                end
            end
        end else begin
            e_aload = (cyc >= t_arb + 1) && (cyc <= t_arb + H);
            if (cyc >= t_arb + H + 1 && r[m_win] == 1'b0) begin
                e_gnt = '0; e_aload = 1'b0; e_gt = '0; e_at = '0;
                m_ptr = (m_win + 1) % 4; m_act = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("GNT",       32'(ifa.GNT),   32'(e_gnt));
        chk("ALOAD",     32'(ifa.ALOAD), 32'(e_aload));
        chk("AD",        32'(ifa.AD),    32'(e_ad));
        chk("BUSY",      32'(ifa.BUSY),  32'(m_act));
        chk("GNT_t",     ifa.GNT_t,      TAINT ? e_gt  : 32'h0);
        chk("ALOAD_t",   ifa.ALOAD_t,    TAINT ? e_at  : 32'h0);
        chk("AD_t",      ifa.AD_t,       TAINT ? e_adt : 32'h0);
        chk("onehot",    32'($onehot0(ifa.GNT)), 32'd1);
        chk("aload_gnt", 32'(!ifa.ALOAD || $onehot(ifa.GNT)), 32'd1);
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic settle();
        ifa.REQ = 4'b0;
        for (int k = 0; k < 12 && m_act; k++) step();
        chk("settle_busy", 32'(ifa.BUSY), 32'd0);
    endtask

    initial begin
        int got_w[5], got_t[5], exp_w[5];
        int ng, idx;
        logic [3:0] prev;
        exp_w = '{0, 1, 2, 3, 0};

        ifa.REQ = '0; ifa.REQ_t = '0; ifa.AD_IN = '0; ifa.AD_IN_t = '0;
        ifb.REQ = '0; ifb.REQ_t = '0; ifb.AD_IN = '0; ifb.AD_IN_t = '0;
        model_reset();

        // Reset state
        #2 ARST_N = 1'b0;
        #2 check_all();
        step();
        ARST_N = 1'b1;

        // Single request: requester 2, value 2'b10, taints 1 and 4
        ifa.REQ = 4'b0100; ifa.AD_IN = 8'b00_10_00_00; ifa.REQ_t = 32'h1; ifa.AD_IN_t = 32'h4;
        step();
        step();
        chk("single_gnt", 32'(ifa.GNT), 32'h4);
        chk("single_no_aload", 32'(ifa.ALOAD), 32'h0);
        ifa.REQ = 4'b0;
        step();
        chk("single_aload", 32'(ifa.ALOAD), 32'h1);
        chk("single_ad", 32'(ifa.AD), 32'h2);
        chk("single_ad_t", ifa.AD_t, TAINT ? 32'h5 : 32'h0);
        chk("single_aload_t", ifa.ALOAD_t, TAINT ? 32'h1 : 32'h0);
        step();
        chk("single_aload_off", 32'(ifa.ALOAD), 32'h0);
        settle();

        // All four requesting from reset: each drops only while granted
        ifa.REQ_t = '0; ifa.AD_IN_t = '0;
        #2 ARST_N = 1'b0;
        #1 model_reset();
        ifa.REQ = 4'b1111;
        step();
        ARST_N = 1'b1;
        ng = 0; prev = '0;
        for (int n = 0; n < 40 && ng < 5; n++) begin
            ifa.REQ = ~e_gnt;
            ifa.AD_IN = 8'($urandom);
            step();
            if (prev == 4'b0 && ifa.GNT != 4'b0) begin
                idx = 0;
                for (int j = 0; j < 4; j++) if (ifa.GNT[j]) idx = j;
                got_w[ng] = idx; got_t[ng] = cyc; ng++;
            end
            prev = ifa.GNT;
        end
        chk("rr_count", 32'(ng), 32'd5);
        for (int k = 0; k < ng; k++) chk("rr_win", 32'(got_w[k]), 32'(exp_w[k]));
        for (int k = 1; k < ng; k++) chk("rr_gap", 32'(got_t[k] - got_t[k-1]), 32'd4);
        settle();

        // X in the request vector while idle
        ifa.REQ = 4'b00x1; ifa.REQ_t = 32'h3; ifa.AD_IN_t = 32'h8;
        step(); step(); step();
        settle();

        // Reset pulsed while ALOAD is high
        ifa.REQ = 4'b1010; ifa.REQ_t = 32'h10; ifa.AD_IN = 8'hB4;
        for (int k = 0; k < 8 && !e_aload; k++) step();
        chk("pre_rst_aload", 32'(ifa.ALOAD), 32'h1);
        #2 ARST_N = 1'b0;
        #1 model_reset();
        chk("rst_aload", 32'(ifa.ALOAD), 32'h0);
        chk("rst_gnt", 32'(ifa.GNT), 32'h0);
        chk("rst_gnt_t", ifa.GNT_t, 32'h0);
        chk("rst_aload_t", ifa.ALOAD_t, 32'h0);
        chk("rst_ad_t", ifa.AD_t, 32'h0);
        step();
        ARST_N = 1'b1;
        step(); step();
        chk("post_rst_gnt", 32'(ifa.GNT), 32'h2);
        ifa.REQ = 4'b0;
        settle();

        // HOLD_CYCLES=3 instance: requester 1 drops REQ during LOAD
        ifb.REQ = 4'b0010; ifb.AD_IN = 8'h0C;
        step(); step();
        chk("h3_gnt", 32'(ifb.GNT), 32'h2);
        chk("h3_ad", 32'(ifb.AD), 32'h3);
        chk("h3_aload0", 32'(ifb.ALOAD), 32'h0);
        ifb.REQ = 4'b0;
        step(); chk("h3_aload1", 32'(ifb.ALOAD), 32'h1);
        step(); chk("h3_aload2", 32'(ifb.ALOAD), 32'h1);
        step(); chk("h3_aload3", 32'(ifb.ALOAD), 32'h1);
        chk("h3_gnt_held", 32'(ifb.GNT), 32'h2);
        step();
        chk("h3_aload_off", 32'(ifb.ALOAD), 32'h0);
        chk("h3_gnt_clr", 32'(ifb.GNT), 32'h0);
        chk("h3_busy", 32'(ifb.BUSY), 32'h0);

        // Randomized requesters: raise at will, drop only once granted
        ifa.REQ = 4'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!ifa.REQ[i]) begin
                    if (!e_gnt[i] && $urandom_range(2) == 0) ifa.REQ[i] = 1'b1;
                end else if (e_gnt[i] && $urandom_range(1) == 0) begin
                    ifa.REQ[i] = 1'b0;
                end
            end
            ifa.AD_IN = 8'($urandom); ifa.REQ_t = $urandom; ifa.AD_IN_t = $urandom;
            step();
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
